// File: rtl/vga_sprite_compositor.sv
// Multi-sprite overlay stage: keyboard-driven sprite motion applied in blanking,
// hit test + sprite ROM fetch + fixed-priority compositing over the background.
module vga_sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 50,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int IDX_W       = 9,
  parameter int STEP        = 4,
  parameter int X_SPACING   = 80,
  parameter int TRANSPARENT = 0,
  parameter int WRAP        = 0,
  parameter int ROM_AW      = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              active,
  input  logic              screen_end,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic [IDX_W-1:0]  bg_idx,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_active,
  output logic [3:0]        hit_id
);

  typedef enum logic [2:0] {
    MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT
  } move_t;

  typedef enum logic [1:0] {IDLE, SNAP, UPDATE} state_t;

  localparam logic signed [11:0] STP  = 12'(STEP);
  localparam logic signed [11:0] XMAX = 12'(SCREEN_W - SPR_W);
  localparam logic signed [11:0] YMAX = 12'(SCREEN_H - SPR_H);
  localparam logic signed [11:0] SW   = 12'(SCREEN_W);
  localparam logic signed [11:0] SH   = 12'(SCREEN_H);

  state_t     state;
  move_t      pend;
  move_t      work;
  move_t      key_mv;
  logic       brk;
  logic       se_q;
  logic [3:0] k;
  logic [9:0] sx [NUM_SPRITES];
  logic [8:0] sy [NUM_SPRITES];

  logic [9:0]        cur_x;
  logic [8:0]        cur_y;
  logic signed [11:0] dx, dy, nx, ny, nxc, nyc;
  logic              key_is_mv;

  always_comb begin
    key_mv = MV_NONE;
    unique case (1'b1)
      key_code == 8'h1D: key_mv = MV_UP;
      key_code == 8'h1B: key_mv = MV_DOWN;
      key_code == 8'h1C: key_mv = MV_LEFT;
      key_code == 8'h23: key_mv = MV_RIGHT;
      default:           key_mv = MV_NONE;
    endcase
  end

  assign key_is_mv = key_valid && !brk && (key_mv != MV_NONE);

  // Next position of the sprite currently being walked
  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (k == 4'(i)) begin
        cur_x = sx[i];
        cur_y = sy[i];
      end
    end
    dx = '0;
    dy = '0;
    unique case (work)
      MV_UP:    dy = -STP;
      MV_DOWN:  dy = STP;
      MV_LEFT:  dx = -STP;
      MV_RIGHT: dx = STP;
      default:  ;
    endcase
    nx  = $signed({2'b00, cur_x}) + dx;
    ny  = $signed({3'b000, cur_y}) + dy;
    nxc = nx;
    nyc = ny;
    if (WRAP != 0) begin
      if (nx < 0)        nxc = nx + SW;
      else if (nx >= SW) nxc = nx - SW;
      if (ny < 0)        nyc = ny + SH;
      else if (ny >= SH) nyc = ny - SH;
    end else begin
      if (nx < 0)         nxc = '0;
      else if (nx > XMAX) nxc = XMAX;
      if (ny < 0)         nyc = '0;
      else if (ny > YMAX) nyc = YMAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= MV_NONE;
      work  <= MV_NONE;
      brk   <= 1'b0;
      se_q  <= 1'b0;
      k     <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx[i] <= 10'(i * X_SPACING);
        sy[i] <= '0;
      end
    end else begin
      se_q <= screen_end;
      if (key_valid) begin
        if (brk)                    brk <= 1'b0;
        else if (key_code == 8'hF0) brk <= 1'b1;
      end
      // A key arriving in SNAP wins over the clear, so it lands next frame
      if (key_is_mv)          pend <= key_mv;
      else if (state == SNAP) pend <= MV_NONE;
      unique case (state)
        IDLE: if (screen_end && !se_q) state <= SNAP;
        SNAP: begin
          work  <= pend;
          k     <= '0;
          state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            if (k == 4'(i)) begin
              sx[i] <= 10'(nxc);
              sy[i] <= 9'(nyc);
            end
          end
          if (k == 4'(NUM_SPRITES - 1)) state <= IDLE;
          else                          k <= k + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic              hit;
  logic [3:0]        hid;
  logic [ROM_AW-1:0] addr;
  logic [9:0]        dxv;
  logic [9:0]        dyv;

  // Walk from the highest index down so the lowest index wins
  always_comb begin
    hit  = 1'b0;
    hid  = 4'hF;
    addr = '0;
    dxv  = '0;
    dyv  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if ({1'b0, x} >= {1'b0, sx[i]} &&
          {1'b0, x} < {1'b0, sx[i]} + 11'(SPR_W) &&
          y >= sy[i] &&
          {1'b0, y} < {1'b0, sy[i]} + 10'(SPR_H)) begin
        hit  = 1'b1;
        hid  = 4'(i);
        dxv  = x - sx[i];
        dyv  = {1'b0, y} - {1'b0, sy[i]};
        addr = ROM_AW'(i * SPR_W * SPR_H) +
               ROM_AW'(dyv * SPR_W) + ROM_AW'(dxv);
      end
    end
  end

  logic             hit0, act0, hit1, act1;
  logic [3:0]       id0, id1;
  logic [IDX_W-1:0] rd1, bg1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr   <= '0;
      hit0       <= 1'b0;
      id0        <= 4'hF;
      act0       <= 1'b0;
      hit1       <= 1'b0;
      id1        <= 4'hF;
      act1       <= 1'b0;
      rd1        <= '0;
      bg1        <= '0;
      pix_idx    <= '0;
      pix_active <= 1'b0;
      hit_id     <= 4'hF;
    end else if (pix_en) begin
      rom_addr   <= addr;
      hit0       <= hit;
      id0        <= hid;
      act0       <= active;
      hit1       <= hit0;
      id1        <= id0;
      act1       <= act0;
      rd1        <= rom_data;
      bg1        <= bg_idx;
      pix_active <= act1;
      if (!act1) begin
        pix_idx <= '0;
        hit_id  <= 4'hF;
      end else if (hit1 && rd1 != IDX_W'(TRANSPARENT)) begin
        pix_idx <= rd1;
        hit_id  <= id1;
      end else begin
        pix_idx <= bg1;
        hit_id  <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: a clamp instance and a wrap
// instance share stimulus, each with its own 1-clk sprite ROM model.
module tb_vga_sprite_compositor;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic        screen_end;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [8:0]  bg_idx;
  logic [13:0] rom_addr, rom_addr_w;
  logic [8:0]  rom_data, rom_data_w;
  logic [8:0]  pix_idx, pix_idx_w;
  logic        pix_active, pix_active_w;
  logic [3:0]  hit_id, hit_id_w;

  int          total = 0;
  int          bad = 0;
  logic        zero_en = 1'b0;
  logic [13:0] zero_at = '0;

  vga_sprite_compositor #(.WRAP(0)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
    .active(active), .screen_end(screen_end), .key_valid(key_valid),
    .key_code(key_code), .bg_idx(bg_idx), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_idx(pix_idx), .pix_active(pix_active),
    .hit_id(hit_id)
  );

  vga_sprite_compositor #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
    .active(active), .screen_end(screen_end), .key_valid(key_valid),
    .key_code(key_code), .bg_idx(bg_idx), .rom_addr(rom_addr_w),
    .rom_data(rom_data_w), .pix_idx(pix_idx_w),
    .pix_active(pix_active_w), .hit_id(hit_id_w)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_fn(input logic [13:0] a);
    if (zero_en && a == zero_at) return 9'h000;
    return {1'b1, a[7:0]};
  endfunction

  always @(posedge clk) begin
    rom_data   <= rom_fn(rom_addr);
    rom_data_w <= rom_fn(rom_addr_w);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic px(input logic [9:0] xv, input logic [8:0] yv,
                    input logic act, input logic [8:0] bg);
    x = xv;
    y = yv;
    active = act;
    bg_idx = bg;
    repeat (3) strobe();
  endtask

  task automatic key(input logic [7:0] c);
    key_code = c;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic frame();
    screen_end = 1'b1;
    repeat (NS + 3) tick();
    screen_end = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    pix_en = 1'b0;
    x = '0;
    y = '0;
    active = 1'b0;
    screen_end = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    bg_idx = '0;
    repeat (3) tick();
    chk("rst_pix_idx", pix_idx, 9'h000);
    chk("rst_pix_act", pix_active, 1'b0);
    chk("rst_hit_id", hit_id, 4'hF);
    chk("rst_rom_addr", rom_addr, 14'd0);
    reset = 1'b1;
    tick();

    // Frame with no keys: positions stay at reset values
    frame();
    px(10'd161, 9'd1, 1'b1, 9'h055);
    chk("s2_in_addr", rom_addr, 14'd5051);
    chk("s2_in_idx", pix_idx, 9'h1BB);
    chk("s2_in_id", hit_id, 4'd2);
    chk("s2_in_act", pix_active, 1'b1);
    px(10'd160, 9'd0, 1'b1, 9'h055);
    chk("s2_edge_idx", pix_idx, 9'h188);
    chk("s2_edge_id", hit_id, 4'd2);
    px(10'd210, 9'd0, 1'b1, 9'h055);
    chk("s2_miss_addr", rom_addr, 14'd0);
    chk("s2_miss_idx", pix_idx, 9'h055);
    chk("s2_miss_id", hit_id, 4'hF);
    px(10'd161, 9'd1, 1'b0, 9'h055);
    chk("inact_idx", pix_idx, 9'h000);
    chk("inact_act", pix_active, 1'b0);

    // Move right by one step
    key(8'h23);
    frame();
    px(10'd4, 9'd0, 1'b1, 9'h011);
    chk("r_s0_id", hit_id, 4'd0);
    chk("r_s0_idx", pix_idx, 9'h100);
    px(10'd3, 9'd0, 1'b1, 9'h011);
    chk("r_s0_left", hit_id, 4'hF);
    chk("r_s0_left_bg", pix_idx, 9'h011);
    px(10'd244, 9'd0, 1'b1, 9'h011);
    chk("r_s3_id", hit_id, 4'd3);
    chk("r_s3_idx", pix_idx, 9'h14C);
    px(10'd243, 9'd0, 1'b1, 9'h011);
    chk("r_s3_left", hit_id, 4'hF);

    // Up from y=0: clamp holds, wrap steps 476, 472, 468
    key(8'h1D);
    frame();
    px(10'd4, 9'd476, 1'b1, 9'h022);
    chk("w1_id", hit_id_w, 4'd0);
    chk("w1_idx", pix_idx_w, 9'h100);
    px(10'd4, 9'd475, 1'b1, 9'h022);
    chk("w1_above", hit_id_w, 4'hF);
    key(8'h1D);
    frame();
    px(10'd4, 9'd472, 1'b1, 9'h022);
    chk("w2_id", hit_id_w, 4'd0);
    px(10'd4, 9'd471, 1'b1, 9'h022);
    chk("w2_above", hit_id_w, 4'hF);
    key(8'h1D);
    frame();
    px(10'd4, 9'd468, 1'b1, 9'h022);
    chk("w3_id", hit_id_w, 4'd0);
    px(10'd4, 9'd0, 1'b1, 9'h022);
    chk("clamp_y_id", hit_id, 4'd0);
    chk("clamp_y_addr", rom_addr, 14'd0);

    // Break code suppresses the following code
    key(8'hF0);
    key(8'h23);
    frame();
    px(10'd4, 9'd0, 1'b1, 9'h033);
    chk("brk_still", hit_id, 4'd0);
    px(10'd3, 9'd0, 1'b1, 9'h033);
    chk("brk_left", hit_id, 4'hF);

    // Latest code in a frame wins
    key(8'h1C);
    key(8'h23);
    frame();
    px(10'd8, 9'd0, 1'b1, 9'h033);
    chk("last_s0", hit_id, 4'd0);
    px(10'd7, 9'd0, 1'b1, 9'h033);
    chk("last_left", hit_id, 4'hF);

    // Push right until sprite 3 clamps at 590 and sprite 2 overlaps it
    for (int f = 0; f < 100; f++) begin
      key(8'h23);
      frame();
    end
    px(10'd600, 9'd0, 1'b1, 9'h033);
    chk("ovl_id", hit_id, 4'd2);
    chk("ovl_idx", pix_idx, 9'h1A8);
    px(10'd620, 9'd0, 1'b1, 9'h033);
    chk("s3_only_id", hit_id, 4'd3);
    chk("s3_only_idx", pix_idx, 9'h16A);
    px(10'd639, 9'd0, 1'b1, 9'h033);
    chk("s3_clamp_idx", pix_idx, 9'h17D);
    px(10'd600, 9'd49, 1'b1, 9'h033);
    chk("ovl_bot_idx", pix_idx, 9'h13A);
    px(10'd600, 9'd50, 1'b1, 9'h033);
    chk("ovl_below_id", hit_id, 4'hF);
    zero_en = 1'b1;
    zero_at = 14'd5032;
    px(10'd600, 9'd0, 1'b1, 9'h033);
    chk("transp_addr", rom_addr, 14'd5032);
    chk("transp_idx", pix_idx, 9'h033);
    chk("transp_id", hit_id, 4'hF);
    zero_en = 1'b0;

    // Key in the SNAP cycle is deferred one frame
    screen_end = 1'b1;
    tick();
    key_code = 8'h1C;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (NS + 2) tick();
    screen_end = 1'b0;
    tick();
    px(10'd408, 9'd0, 1'b1, 9'h044);
    chk("snap_hold", hit_id, 4'd0);
    px(10'd407, 9'd0, 1'b1, 9'h044);
    chk("snap_hold_l", hit_id, 4'hF);
    frame();
    px(10'd404, 9'd0, 1'b1, 9'h044);
    chk("snap_next", hit_id, 4'd0);
    px(10'd403, 9'd0, 1'b1, 9'h044);
    chk("snap_next_l", hit_id, 4'hF);

    // Reset in the middle of UPDATE with a pending key
    key(8'h23);
    screen_end = 1'b1;
    repeat (3) tick();
    key_code = 8'h1B;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_act", pix_active, 1'b0);
    chk("arst_id", hit_id, 4'hF);
    tick();
    screen_end = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    frame();
    px(10'd0, 9'd0, 1'b1, 9'h055);
    chk("mr_s0", hit_id, 4'd0);
    px(10'd80, 9'd0, 1'b1, 9'h055);
    chk("mr_s1", hit_id, 4'd1);
    chk("mr_s1_idx", pix_idx, 9'h1C4);
    px(10'd160, 9'd0, 1'b1, 9'h055);
    chk("mr_s2", hit_id, 4'd2);
    px(10'd240, 9'd0, 1'b1, 9'h055);
    chk("mr_s3", hit_id, 4'd3);
    chk("mr_s3_idx", pix_idx, 9'h14C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
